// File: rtl/seed_scanner.sv
// Seed scanner: latches a 22-bit query seed, slides it across each database
// word in nucleotide steps and hands every exact hit to the extension stage.
module seed_scanner #(
  parameter int DB_WIDTH  = 512,
  parameter int SEED_BITS = 22,
  parameter int STEP      = 2,
  parameter int MAX_SHIFT = DB_WIDTH - SEED_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                queryValid,
  input  logic [DB_WIDTH-1:0] inQuery,
  input  logic [8:0]          LocationQ,
  input  logic                dbValid,
  input  logic [DB_WIDTH-1:0] inDB,
  input  logic [16:0]         dbCounter,
  input  logic                dbLast,
  output logic                dbReady,
  input  logic                load,
  input  logic                stop,
  output logic                start,
  output logic [8:0]          shiftNo,
  output logic [16:0]         dataCounter,
  output logic                queryErr,
  output logic [15:0]         hitCount,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, SCAN, HIT, WAITX, DRAIN} state_t;

  localparam logic [8:0] LAST_S = 9'(MAX_SHIFT);
  localparam logic [8:0] STEP_S = 9'(STEP);

  state_t               state_q;
  logic [SEED_BITS-1:0] seed_q;
  logic                 seed_valid_q;
  logic [DB_WIDTH-1:0]  word_q;
  logic [16:0]          idx_q;
  logic                 last_q;
  logic [8:0]           s_q;
  logic                 stop_seen_q;
  logic                 start_q;
  logic [8:0]           shift_q;
  logic [16:0]          dcnt_q;
  logic                 qerr_q;
  logic [15:0]          hits_q;
  logic                 done_q;

  logic [SEED_BITS-1:0] seed_d;
  logic [8:0]           s_d;
  logic                 loc_bad;
  logic                 match;
  logic                 at_end;

  always_comb begin
    seed_d  = SEED_BITS'(inQuery >> LocationQ);
    loc_bad = LocationQ[0] | (LocationQ > LAST_S);
    match   = (SEED_BITS'(word_q >> s_q) == seed_q);
    at_end  = (s_q == LAST_S);
    s_d     = s_q + STEP_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      word_q       <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      s_q          <= '0;
      stop_seen_q  <= 1'b0;
      start_q      <= 1'b0;
      shift_q      <= '0;
      dcnt_q       <= '0;
      qerr_q       <= 1'b0;
      hits_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (queryValid) begin
            seed_q       <= seed_d;
            seed_valid_q <= ~loc_bad;
            qerr_q       <= loc_bad;
            hits_q       <= '0;
          end else if (dbValid && seed_valid_q) begin
            word_q  <= inDB;
            idx_q   <= dbCounter;
            last_q  <= dbLast;
            s_q     <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            shift_q <= s_q;
            dcnt_q  <= idx_q;
            start_q <= ~stop;
            state_q <= HIT;
          end else if (!at_end) begin
            s_q <= s_d;
          end else if (last_q) begin
            done_q  <= 1'b1;
            state_q <= DRAIN;
          end else begin
            state_q <= IDLE;
          end
        end
        HIT: begin
          // start is withheld while the extension stage still reports stop
          if (!start_q) begin
            if (!stop) start_q <= 1'b1;
          end else if (load) begin
            start_q     <= 1'b0;
            stop_seen_q <= 1'b0;
            if (hits_q != '1) hits_q <= hits_q + 16'd1;
            state_q     <= WAITX;
          end
        end
        WAITX: begin
          if (!stop_seen_q) begin
            if (stop) stop_seen_q <= 1'b1;
          end else if (!stop) begin
            if (!at_end) begin
              s_q     <= s_d;
              state_q <= SCAN;
            end else if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DRAIN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbReady     = (state_q == IDLE) & seed_valid_q;
  assign start       = start_q;
  assign shiftNo     = shift_q;
  assign dataCounter = dcnt_q;
  assign queryErr    = qerr_q;
  assign hitCount    = hits_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seed_scanner.sv
// Scoreboard bench for seed_scanner: expected hits are queued as stimulus is
// issued and a negedge monitor pops and compares them on every start rise.
module tb_seed_scanner;

  localparam logic [21:0] SEED_A = 22'h2AB3C1;
  localparam logic [21:0] SEED_B = 22'h155555;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         queryValid = 1'b0;
  logic [511:0] inQuery = '0;
  logic [8:0]   LocationQ = '0;
  logic         dbValid = 1'b0;
  logic [511:0] inDB = '0;
  logic [16:0]  dbCounter = '0;
  logic         dbLast = 1'b0;
  logic         dbReady;
  logic         load = 1'b0;
  logic         stop = 1'b0;
  logic         start;
  logic [8:0]   shiftNo;
  logic [16:0]  dataCounter;
  logic         queryErr;
  logic [15:0]  hitCount;
  logic         done;

  seed_scanner #(.DB_WIDTH(512), .SEED_BITS(22), .STEP(2)) dut (
    .clk(clk), .rst(rst), .queryValid(queryValid), .inQuery(inQuery),
    .LocationQ(LocationQ), .dbValid(dbValid), .inDB(inDB),
    .dbCounter(dbCounter), .dbLast(dbLast), .dbReady(dbReady), .load(load),
    .stop(stop), .start(start), .shiftNo(shiftNo), .dataCounter(dataCounter),
    .queryErr(queryErr), .hitCount(hitCount), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [8:0]  sh;
    logic [16:0] dc;
  } hit_t;
  hit_t expq[$];
  hit_t exp_m;

  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   done_cnt = 0;
  logic start_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (start && !start_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
      check("start_expected", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        exp_m = expq.pop_front();
        check("hit_shiftNo", 32'(shiftNo), 32'(exp_m.sh));
        check("hit_dataCounter", 32'(dataCounter), 32'(exp_m.dc));
      end
    end
    start_prev = start;
  end

  task automatic load_query(input logic [511:0] q, input logic [8:0] loc);
    @(posedge clk); #1;
    queryValid = 1'b1; inQuery = q; LocationQ = loc;
    @(posedge clk); #1;
    queryValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [511:0] w, input logic [16:0] cnt,
                           input logic last, output int acc);
    @(negedge clk);
    check("dbReady_before_word", 32'(dbReady), 1);
    @(posedge clk); #1;
    inDB = w; dbCounter = cnt; dbLast = last; dbValid = 1'b1;
    @(posedge clk); #1;
    dbValid = 1'b0; dbLast = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_rise(input int target, input string nm);
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      if (rise_cnt >= target) break;
    end
    check(nm, 32'(rise_cnt >= target), 1);
  endtask

  task automatic handshake(input int target);
    wait_rise(target, "start_seen");
    #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    check("start_drop_after_load", 32'(start), 0);
    @(posedge clk); #1 stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic wait_ready(input int acc, output int d);
    d = 9999;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dbReady) begin
        d = cyc - acc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] qa, qb, w;
    int acc, d, r0, rel;

    #3;
    check("rst_start", 32'(start), 0);
    check("rst_dbReady", 32'(dbReady), 0);
    check("rst_hitCount", 32'(hitCount), 0);
    check("rst_queryErr", 32'(queryErr), 0);
    check("rst_done", 32'(done), 0);
    check("rst_shiftNo", 32'(shiftNo), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("dbReady_no_seed", 32'(dbReady), 0);

    // single hit at offset 40 of word 5
    qa = '0; qa[100 +: 22] = SEED_A;
    load_query(qa, 9'd100);
    check("qerr_loc100", 32'(queryErr), 0);
    check("dbReady_seed", 32'(dbReady), 1);
    w = '0; w[40 +: 22] = SEED_A;
    expq.push_back('{sh: 9'd40, dc: 17'd5});
    send_word(w, 17'd5, 1'b0, acc);
    handshake(1);
    check("start_latency", 32'(rise_cyc - acc), 21);
    wait_ready(acc, d);
    check("ready_after_hit_word", 32'(d < 400), 1);
    check("hitCount_one", 32'(hitCount), 1);
    check("single_hit_only", 32'(rise_cnt), 1);

    // no-match word
    w = '1;
    send_word(w, 17'd6, 1'b0, acc);
    wait_ready(acc, d);
    check("nomatch_ready_delay", 32'(d), 246);
    check("nomatch_no_start", 32'(rise_cnt), 1);
    check("no_done_yet", 32'(done_cnt), 0);

    // overlapping hits 0, 2, 490 on the last word
    qb = '0; qb[21:0] = SEED_B;
    load_query(qb, 9'd0);
    check("hitCount_cleared", 32'(hitCount), 0);
    w = '0; w[23:0] = 24'h555555; w[511:490] = SEED_B;
    expq.push_back('{sh: 9'd0,   dc: 17'd9});
    expq.push_back('{sh: 9'd2,   dc: 17'd9});
    expq.push_back('{sh: 9'd490, dc: 17'd9});
    send_word(w, 17'd9, 1'b1, acc);
    handshake(2);
    handshake(3);
    handshake(4);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    repeat (3) @(posedge clk);
    check("done_pulse_once", 32'(done_cnt), 1);
    check("hitCount_three", 32'(hitCount), 3);
    check("queue_drained", 32'(expq.size()), 0);

    // stop held high when the hit is found
    stop = 1'b1;
    w = '0; w[21:0] = SEED_B;
    expq.push_back('{sh: 9'd0, dc: 17'd12});
    send_word(w, 17'd12, 1'b0, acc);
    r0 = rise_cnt;
    repeat (8) @(posedge clk);
    check("start_held_by_stop", 32'(rise_cnt), 32'(r0));
    @(negedge clk);
    check("start_low_while_stop", 32'(start), 0);
    @(posedge clk); #1 stop = 1'b0;
    rel = cyc;
    wait_rise(r0 + 1, "start_after_stop");
    check("start_after_stop_delay", 32'(rise_cyc - rel), 1);

    // asynchronous reset during HIT
    check("hitCount_pre_reset", 32'(hitCount), 3);
    check("start_pre_reset", 32'(start), 1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_start", 32'(start), 0);
    check("arst_hitCount", 32'(hitCount), 0);
    check("arst_shiftNo", 32'(shiftNo), 0);
    check("arst_dataCounter", 32'(dataCounter), 0);
    check("arst_dbReady", 32'(dbReady), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("seed_discarded", 32'(dbReady), 0);

    // illegal seed locations
    r0 = rise_cnt;
    load_query(qa, 9'd491);
    check("qerr_loc491", 32'(queryErr), 1);
    check("dbReady_loc491", 32'(dbReady), 0);
    w = '0; w[21:0] = SEED_A;
    @(posedge clk); #1 inDB = w; dbValid = 1'b1;
    repeat (5) @(posedge clk);
    #1 dbValid = 1'b0;
    @(negedge clk);
    check("dbReady_still0_491", 32'(dbReady), 0);
    load_query(qa, 9'd7);
    check("qerr_loc7", 32'(queryErr), 1);
    @(posedge clk); #1 dbValid = 1'b1;
    repeat (5) @(posedge clk);
    #1 dbValid = 1'b0;
    repeat (5) @(negedge clk);
    check("dbReady_still0_7", 32'(dbReady), 0);
    check("no_start_bad_loc", 32'(rise_cnt), 32'(r0));

    load_query(qa, 9'd100);
    check("qerr_cleared", 32'(queryErr), 0);
    check("dbReady_reloaded", 32'(dbReady), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seed_scanner.md
# seed_scanner

Upstream feeder for the seed-extension FSM. Latches a 22-bit query seed, accepts 512-bit database words one at a time and slides the seed across each word in 2-bit (one-nucleotide) steps, one comparison per cycle. On every exact seed hit it presents `start`, `shiftNo` and `dataCounter` to the extension stage. It then stalls until that stage reports completion on `stop`, then resumes the scan at the next offset.

## Interface
Parameters:
- `DB_WIDTH`, 512, bits per database/query word
- `SEED_BITS`, 22, seed length in bits (11 nucleotides)
- `STEP`, 2, scan stride in bits
- `MAX_SHIFT`, `DB_WIDTH-SEED_BITS` (490), last scanned offset

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `queryValid` in 1 — `inQuery`/`LocationQ` valid; sampled only in IDLE
- `inQuery` in 512 — query word
- `LocationQ` in 9 — bit offset of seed in `inQuery`
- `dbValid` in 1 — database word valid
- `inDB` in 512 — database word
- `dbCounter` in 17 — word index of `inDB`
- `dbLast` in 1 — qualifies final word of the database (with `dbValid`)
- `dbReady` out 1 — scanner can accept a word this cycle
- `load` in 1 — extension stage accepted the hit (its load request)
- `stop` in 1 — extension stage finished (level, cleared by that stage in its IDLE)
- `start` out 1 — hit pending
- `shiftNo` out 9 — bit offset of hit within the word
- `dataCounter` out 17 — word index of hit
- `queryErr` out 1 — latched seed location illegal
- `hitCount` out 16 — hits reported since last query load, saturating at 16'hFFFF
- `done` out 1 — one-cycle pulse after the last word is fully scanned

## Operation
- Reset values: `dbReady`=0 until first cycle after reset release, then per state; `start`, `done`, `queryErr`=0; `shiftNo`, `dataCounter`, `hitCount`=0; internal `seedValid`=0; state IDLE.
- States: IDLE, SCAN, HIT, WAITX, DRAIN.
- IDLE: `dbReady`=`seedValid`. On `queryValid`:
  - latch `seed = inQuery[LocationQ +: 22]` and set `seedValid`=1, clear `hitCount`, clear `queryErr`.
  - If `LocationQ` is odd or >490, set `queryErr`=1 and `seedValid`=0 instead.
  - `queryValid` has priority over `dbValid` in the same cycle; the word is not accepted.
- IDLE with `dbValid & dbReady`: latch `inDB`, `dbCounter`, `dbLast`; set offset s=0; go SCAN.
- SCAN: each cycle compare `word[s +: 22]` with `seed`.
  - Match: register `shiftNo`=s, `dataCounter`=latched index, `start`=1; go HIT.
  - No match and s<490: s+=2.
  - No match and s==490: go IDLE, or DRAIN if the word carried `dbLast`.
- HIT: hold `start`, `shiftNo`, `dataCounter` stable. Do not assert while `stop`=1; wait until `stop`=0 before `start` rises. On `load`=1: `start`=0, `hitCount`+=1 (saturating); go WAITX.
- WAITX: wait for `stop`=1, then for `stop`=0.
  - Then if s<490: s+=2 and return to SCAN.
  - Else: go IDLE, or DRAIN if the word carried `dbLast`.
- DRAIN: `done`=1 for one cycle; `seedValid` stays set; go IDLE.
- `queryValid` outside IDLE is ignored. `dbValid` outside IDLE is ignored and no word is consumed.
- Arithmetic: s is 9 bits and counts 0..490 in steps of 2, never wrapping. `hitCount` saturates and does not wrap.
- Reset asserted mid-scan or mid-hit aborts immediately; all outputs return to reset values and the seed is discarded.

## Timing
- Word accepted at edge T. Offset s is compared in cycle T+1+s/2.
- A match in cycle c gives `start`=1 from cycle c+1.
- No-hit word: SCAN occupies cycles T+1..T+246; `dbReady`=1 in cycle T+247.
- After `load`, the scan of offset s+2 resumes one cycle after `stop` is seen falling.
- `done` is asserted in the cycle after the final SCAN/WAITX cycle of the last word.
- `shiftNo`/`dataCounter` change only on entry to HIT. They are stable throughout HIT and WAITX, because the extension stage samples them in its IDLE.

## Test plan
- Query with `LocationQ`=100 and seed 22'h2AB3C1. Word 5 contains the seed only at offset 40. Expect `start`↑ in cycle T+22 with `shiftNo`=40 and `dataCounter`=5. Drive `load`, then `stop` pulse. Expect no further start, `dbReady` back after scan ends, `hitCount`=1.
- Word with the seed at offsets 0, 2 and 490 (overlapping hits). Expect three hits in order 0, 2, 490, each waiting for the `stop` handshake. Expect `hitCount`=3, then `done` pulse when `dbLast`=1.
- No-match word: expect no `start` and `dbReady`=1 exactly 247 cycles after acceptance.
- `LocationQ`=491 and `LocationQ`=7: expect `queryErr`=1, `dbReady` stays 0, and no word consumed.
- `stop` held high when a hit is found: expect `start` to stay 0 until `stop`=0, then `start` rises the next cycle.
- `rst` pulsed during HIT with `start`=1: expect `start`, `hitCount`, `shiftNo`=0 asynchronously and `dbReady`=0 until a new query is loaded.
